// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A) and mult/div (B)
// writeback paths, with a pending scoreboard of destinations still owed by B.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              mark_valid,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_regwrite,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              hazard,
    output logic [31:0]       pending
);

    localparam int unsigned NREG = 32;

    logic              last_b;
    logic              rf_src_b;
    logic              grant_a_c;
    logic              grant_b_c;
    logic              xfer_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_data_c;
    logic [NREG-1:0]   pending_nxt_c;

    // A wins unless B alone is valid, or both are valid and A was granted last
    always_comb begin
        grant_a_c = a_valid & (~b_valid | last_b);
        grant_b_c = b_valid & ~grant_a_c;
    end

    assign a_ready    = grant_a_c & rst_n;
    assign b_ready    = grant_b_c & rst_n;
    assign xfer_c     = a_ready | b_ready;
    assign sel_addr_c = grant_a_c ? a_addr : b_addr;
    assign sel_data_c = grant_a_c ? a_data : b_data;

    // Clear the committing B destination, then apply any new mark so a same-edge set wins
    always_comb begin
        pending_nxt_c = pending;
        if (rf_regwrite && rf_src_b) begin
            pending_nxt_c[rf_wa] = 1'b0;
        end
        if (mark_valid && (mark_addr != '0)) begin
            pending_nxt_c[mark_addr] = 1'b1;
        end
        pending_nxt_c[0] = 1'b0;
    end

    assign hazard = rst_n & (pending[ra1] | pending[ra2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b      <= 1'b1;
            rf_src_b    <= 1'b0;
            rf_wa       <= '0;
            rf_wd       <= '0;
            rf_regwrite <= 1'b0;
            pending     <= '0;
        end else begin
            pending <= pending_nxt_c;
            if (xfer_c) begin
                last_b      <= grant_b_c;
                rf_src_b    <= grant_b_c;
                rf_wa       <= sel_addr_c;
                rf_wd       <= sel_data_c;
                rf_regwrite <= (sel_addr_c != '0);
            end else begin
                rf_regwrite <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a transaction-level reference model.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, mark_valid;
    logic        a_ready, b_ready, rf_regwrite, hazard;
    logic [4:0]  a_addr, b_addr, mark_addr, ra1, ra2, rf_wa;
    logic [31:0] a_data, b_data, rf_wd, pending;

    int checks = 0;
    int errors = 0;

    // reference model state: last winner, owed registers, the write presented to the register file
    bit          m_last_b;
    bit          m_owed [32];
    bit          m_we;
    bit          m_src_b;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          last_ga, last_gb;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .mark_valid(mark_valid), .mark_addr(mark_addr),
        .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_regwrite(rf_regwrite),
        .ra1(ra1), .ra2(ra2), .hazard(hazard), .pending(pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] owed_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_owed[i];
        return v;
    endfunction

    task automatic model_reset();
        m_last_b = 1'b1;
        m_we = 1'b0;
        m_src_b = 1'b0;
        m_wa = '0;
        m_wd = '0;
        for (int i = 0; i < 32; i++) m_owed[i] = 1'b0;
    endtask

    // One clock with the current inputs: check combinational outputs, advance model, check registers
    task automatic cycle();
        bit ga, gb, hz;
        #1;
        if (a_valid && b_valid) begin
            ga = m_last_b;
            gb = !m_last_b;
        end else begin
            ga = a_valid;
            gb = b_valid;
        end
        hz = m_owed[ra1] || m_owed[ra2];
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        check("hazard", hazard, hz);
        @(posedge clk);
        if (m_we && m_src_b) m_owed[m_wa] = 1'b0;
        if (mark_valid && mark_addr != 0) m_owed[mark_addr] = 1'b1;
        m_we = 1'b0;
        if (ga || gb) begin
            m_wa = ga ? a_addr : b_addr;
            m_wd = ga ? a_data : b_data;
            m_we = (m_wa != 0);
            m_src_b = gb;
            m_last_b = gb;
        end
        last_ga = ga;
        last_gb = gb;
        #1;
        check("rf_regwrite", rf_regwrite, m_we);
        check("rf_wa", rf_wa, m_wa);
        check("rf_wd", rf_wd, m_wd);
        check("pending", pending, owed_vec());
    endtask

    initial begin
        logic [4:0] cont_wa [4];
        cont_wa = '{5'd1, 5'd2, 5'd1, 5'd2};

        rst_n = 1'b0;
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0;
        b_valid = 1'b0; b_addr = '0;   b_data = 32'h0;
        mark_valid = 1'b0; mark_addr = '0;
        ra1 = '0; ra2 = '0;
        model_reset();
        #12;
        check("rst_regwrite", rf_regwrite, 0);
        check("rst_wa", rf_wa, 0);
        check("rst_wd", rf_wd, 0);
        check("rst_pending", pending, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_hazard", hazard, 0);
        a_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // A alone
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
        cycle();
        check("a_only_we", rf_regwrite, 1);
        check("a_only_wa", rf_wa, 5);
        check("a_only_wd", rf_wd, 32'hDEAD_BEEF);
        a_valid = 1'b0;
        cycle();
        check("a_only_we_drop", rf_regwrite, 0);

        // B write to register 0 is accepted but suppressed
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
        cycle();
        check("r0_b_granted", last_gb, 1);
        check("r0_we", rf_regwrite, 0);
        check("r0_pending", pending, 0);
        b_valid = 1'b0;

        // contention alternates starting with A
        a_valid = 1'b1; a_addr = 5'd1; a_data = $urandom;
        b_valid = 1'b1; b_addr = 5'd2; b_data = $urandom;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("cont_wa", rf_wa, cont_wa[i]);
            check("cont_we", rf_regwrite, 1);
            if (last_ga) a_data = $urandom;
            else         b_data = $urandom;
        end
        a_valid = 1'b0; b_valid = 1'b0;

        // scoreboard on r7
        ra1 = 5'd7; ra2 = 5'd0;
        mark_valid = 1'b1; mark_addr = 5'd7;
        cycle();
        mark_valid = 1'b0;
        check("mark7_hazard", hazard, 1);
        a_valid = 1'b1; a_addr = 5'd7; a_data = $urandom;
        cycle();
        a_valid = 1'b0;
        cycle();
        check("a_write7_keeps", hazard, 1);
        b_valid = 1'b1; b_addr = 5'd7; b_data = $urandom;
        cycle();
        b_valid = 1'b0;
        check("b7_inflight_hazard", hazard, 1);
        cycle();
        check("b7_cleared_hazard", hazard, 0);

        // same-edge set and clear on r9
        ra1 = 5'd9;
        mark_valid = 1'b1; mark_addr = 5'd9;
        cycle();
        mark_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd9; b_data = $urandom;
        cycle();
        b_valid = 1'b0;
        mark_valid = 1'b1; mark_addr = 5'd9;
        cycle();
        mark_valid = 1'b0;
        check("same_edge_p9", pending[9], 1);
        check("same_edge_hazard", hazard, 1);

        // async reset between transfer and commit
        a_valid = 1'b1; a_addr = 5'd3; a_data = $urandom;
        cycle();
        b_valid = 1'b1; b_addr = 5'd4; b_data = $urandom;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", rf_regwrite, 0);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_a_ready", a_ready, 0);
        check("mid_rst_b_ready", b_ready, 0);
        check("mid_rst_hazard", hazard, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("post_rst_a_wins", rf_wa, 3);
        cycle();
        check("post_rst_b_next", rf_wa, 4);
        a_valid = 1'b0; b_valid = 1'b0;
        cycle();

        // randomized traffic with stable-until-transfer requesters
        for (int n = 0; n < 400; n++) begin
            if (!a_valid || last_ga) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_addr  = 5'($urandom_range(0, 15));
                a_data  = $urandom;
            end
            if (!b_valid || last_gb) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_addr  = 5'($urandom_range(0, 15));
                b_data  = $urandom;
            end
            mark_valid = ($urandom_range(0, 3) == 0);
            mark_addr  = 5'($urandom_range(0, 15));
            ra1 = 5'($urandom_range(0, 15));
            ra2 = 5'($urandom_range(0, 15));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between the single-cycle ALU writeback path (requester A) and the multicycle mult/div unit (requester B) using round-robin arbitration with valid/ready handshakes. It drives the register file's `wa`/`wd`/`regwrite` inputs from registered outputs. It also keeps a 32-bit pending scoreboard of destinations owed by requester B, so decode can stall reads of not-yet-written registers. The block sits between the writeback sources and the register file in the single-cycle/multicycle MIPS datapath.

## Interface
- `DATA_W`, default 32: write data width.
- `ADDR_W`, default 5: register address width (32 registers).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  requester A has a write.
- `a_ready`  out  1  A write accepted this cycle (combinational).
- `a_addr`  in  ADDR_W  A destination register.
- `a_data`  in  DATA_W  A write data.
- `b_valid`, `b_ready`, `b_addr`, `b_data`: same as the A signals, for requester B.
- `mark_valid`  in  1  dispatch issues a B operation.
- `mark_addr`  in  ADDR_W  destination of that B operation.
- `rf_wa`  out  ADDR_W  register file write address (registered).
- `rf_wd`  out  DATA_W  register file write data (registered).
- `rf_regwrite`  out  1  register file write enable (registered).
- `ra1`, `ra2`  in  ADDR_W  decode read addresses.
- `hazard`  out  1  `ra1` or `ra2` is pending (combinational).
- `pending`  out  32  scoreboard vector (registered).

## Operation
- **Transfer:** a request transfers on `x_valid & x_ready`. At most one transfer occurs per cycle.
- **Arbitration:** round-robin on a 1-bit `last` flag.
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last wins.
  - `last` updates only on a transfer.
  - Reset value of `last` is B, so A wins the first tie.
- **Ready rules:**
  - `x_ready` = `x_valid & grant_x & rst_n`.
  - `x_ready` never asserts without `x_valid`.
  - A requester holds `valid`, `addr` and `data` stable until its transfer.
- **Output register:**
  - On a transfer, `rf_wa`/`rf_wd` load the granted addr/data.
  - `rf_regwrite` <= 1 only if addr != 0. A write to register 0 is accepted (ready=1) but suppressed; register 0 stays zero.
  - With no transfer, `rf_regwrite` <= 0, and `rf_wa`/`rf_wd` hold their values.
  - An internal `rf_src` bit records whether the registered write came from B.
- **Scoreboard:**
  - Set: on `mark_valid` with `mark_addr` != 0, set `pending[mark_addr]`. Bit 0 is never set.
  - Clear: when `rf_regwrite & rf_src==B` is high at a clock edge, clear `pending[rf_wa]`.
  - A writes never touch `pending`.
  - Set and clear of the same bit on the same edge: set wins (a new B op is outstanding).
  - Marking an already-pending register leaves it set. Dispatch must not issue a second B op to a pending register; `hazard` enforces this upstream.
  - A B write to a non-pending register still commits; the clear is a no-op.
- **Hazard:** `hazard` = `pending[ra1] | pending[ra2]`. Address 0 never hazards. Because the clear happens on the same edge as the register file write, the in-flight cycle is still covered.

## Timing
- **Reset (async, `rst_n` low):** `rf_regwrite`=0, `rf_wa`=0, `rf_wd`=0, `pending`=0, `last`=B, `rf_src`=A. `a_ready`/`b_ready` are forced 0 and `hazard` reads 0.
- **Reset mid-operation:** an in-flight registered write is dropped, with no register file write. Requesters keep `valid` asserted and retry after release.
- **Write latency:** transfer in cycle N → `rf_regwrite` high in cycle N+1 → the register file captures at the rising edge ending N+1.
- **Scoreboard latency:** a pending bit cleared at the end of N+1 means `hazard` deasserts in N+2. A mark in cycle M makes `hazard` visible in M+1.
- **Throughput:** one write per cycle.
  - Both requesters continuously valid alternate A, B, A, B...
  - A single continuously valid requester gets back-to-back grants.

## Test plan
- **Reset, then A only:** a_valid=1, a_addr=5, a_data=0xDEAD_BEEF for one cycle → a_ready=1 same cycle; next cycle rf_regwrite=1, rf_wa=5, rf_wd=0xDEADBEEF; the cycle after, rf_regwrite=0.
- **Contention:** a_valid=b_valid=1 held for 4 transfers (A→r1, B→r2, fresh data each) → grants A, B, A, B; rf_wa sequence 1, 2, 1, 2 on consecutive cycles, no bubbles.
- **Register 0:** b_valid=1, b_addr=0, b_data=0x1234 → b_ready=1; rf_regwrite stays 0; pending unchanged.
- **Scoreboard:**
  - mark_valid with mark_addr=7, then ra1=7 → hazard=1 from the next cycle.
  - B transfer to 7 in cycle N → hazard still 1 in N+1, 0 in N+2.
  - An A write to 7 meanwhile does not clear pending[7].
- **Same-edge set and clear:** pending[9] set; B write to 9 committing while mark_valid with mark_addr=9 → pending[9] remains 1.
- **Async reset mid-write:** assert rst_n=0 between the transfer and its commit cycle → rf_regwrite drops immediately; pending=0; ready=0 during reset; after release, A wins the first tie.
